cond_exec_stage: RTL and testbench

COND_EXEC_STAGE -- requirements
Module: cond_exec_stage

---
 rtl/cond_exec_stage.sv | 132 +++++++++++++
 tb/tb_cond_exec_stage.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cond_exec_stage.sv
// cond_exec_stage: conditional-execution unit sitting between Execute and Memory.
// Evaluates the ARM condition field against the architectural flag register,
// gates the side-effecting controls, owns the NZCV register and the E->M
// pipeline register.
// Optional build macro: COND_EXEC_SQUASH_CNT_EN adds a 16-bit counter (and the
// SquashCount port) of instructions squashed because their condition failed.
module cond_exec_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        EnM,
  input  logic        FlushE,
  input  logic        PCSrcE,
  input  logic        RegWriteE,
  input  logic        MemtoRegE,
  input  logic        MemWriteE,
  input  logic [1:0]  FlagWriteE,
  input  logic [3:0]  CondE,
  input  logic [3:0]  RdE,
  input  logic [3:0]  ALUFlags,
  input  logic [31:0] ALUResultE,
  input  logic [31:0] WriteDataE,
  output logic [3:0]  Flags,
  output logic        CondExE,
  output logic        BranchTakenE,
  output logic        PCSrcM,
  output logic        RegWriteM,
  output logic        MemtoRegM,
  output logic        MemWriteM,
  output logic [3:0]  RdM,
  output logic [31:0] ALUResultM,
  output logic [31:0] WriteDataM
`ifdef COND_EXEC_SQUASH_CNT_EN
  ,
  output logic [15:0] SquashCount
`endif
);

  logic       flag_n;
  logic       flag_z;
  logic       flag_c;
  logic       flag_v;
  logic       issue;
  logic       pcsrc_gated;
  logic       regwrite_gated;
  logic       memwrite_gated;
  logic [1:0] flagwrite_gated;

  // Flags are taken straight from the register: no bypass from this cycle's ALU.
  assign flag_n = Flags[3];
  assign flag_z = Flags[2];
  assign flag_c = Flags[1];
  assign flag_v = Flags[0];

  // Condition-field decode against the current flag register.
  always_comb begin
    CondExE = 1'b0;
    case (CondE)
      4'h0:    CondExE = flag_z;
      4'h1:    CondExE = ~flag_z;
      4'h2:    CondExE = flag_c;
      4'h3:    CondExE = ~flag_c;
      4'h4:    CondExE = flag_n;
      4'h5:    CondExE = ~flag_n;
      4'h6:    CondExE = flag_v;
      4'h7:    CondExE = ~flag_v;
      4'h8:    CondExE = flag_c & ~flag_z;
      4'h9:    CondExE = ~flag_c | flag_z;
      4'hA:    CondExE = (flag_n == flag_v);
      4'hB:    CondExE = (flag_n != flag_v);
      4'hC:    CondExE = ~flag_z & (flag_n == flag_v);
      4'hD:    CondExE = flag_z | (flag_n != flag_v);
      default: CondExE = 1'b1;
    endcase
  end

  // An instruction only takes effect if its condition passes and it is not flushed.
  assign issue           = CondExE & ~FlushE;
  assign pcsrc_gated     = PCSrcE & issue;
  assign regwrite_gated  = RegWriteE & issue;
  assign memwrite_gated  = MemWriteE & issue;
  assign flagwrite_gated = FlagWriteE & {2{issue}};
  assign BranchTakenE    = pcsrc_gated;

  // E->M pipeline register; EnM=0 freezes it, flush zeroes only the side-effecting controls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PCSrcM     <= 1'b0;
      RegWriteM  <= 1'b0;
      MemtoRegM  <= 1'b0;
      MemWriteM  <= 1'b0;
      RdM        <= 4'h0;
      ALUResultM <= 32'h0;
      WriteDataM <= 32'h0;
    end else if (EnM) begin
      PCSrcM     <= pcsrc_gated;
      RegWriteM  <= regwrite_gated;
      MemtoRegM  <= MemtoRegE;
      MemWriteM  <= memwrite_gated;
      RdM        <= RdE;
      ALUResultM <= ALUResultE;
      WriteDataM <= WriteDataE;
    end
  end

  // Architectural NZCV; the N,Z and C,V halves are written independently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Flags <= 4'h0;
    end else if (EnM) begin
      if (flagwrite_gated[1]) Flags[3:2] <= ALUFlags[3:2];
      if (flagwrite_gated[0]) Flags[1:0] <= ALUFlags[1:0];
    end
  end

`ifdef COND_EXEC_SQUASH_CNT_EN
  logic squash_event;

  // Count instructions that would have had an effect but failed their condition.
  assign squash_event = EnM & ~FlushE & ~CondExE &
                        (PCSrcE | RegWriteE | MemWriteE | (|FlagWriteE));

  // Free-running 16-bit counter that wraps at 0xFFFF.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      SquashCount <= 16'h0;
    end else if (squash_event) begin
      SquashCount <= SquashCount + 16'h1;
    end
  end
`endif

endmodule

// File: tb/tb_cond_exec_stage.sv
// Bench for cond_exec_stage: condition-decode table, directed corner sequences
// and random traffic against a behavioural model of the stage.
module tb_cond_exec_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        EnM, FlushE, PCSrcE, RegWriteE, MemtoRegE, MemWriteE;
  logic [1:0]  FlagWriteE;
  logic [3:0]  CondE, RdE, ALUFlags;
  logic [31:0] ALUResultE, WriteDataE;
  logic [3:0]  Flags;
  logic        CondExE, BranchTakenE;
  logic        PCSrcM, RegWriteM, MemtoRegM, MemWriteM;
  logic [3:0]  RdM;
  logic [31:0] ALUResultM, WriteDataM;
`ifdef COND_EXEC_SQUASH_CNT_EN
  logic [15:0] SquashCount;
`endif

  cond_exec_stage dut (
    .clk(clk), .reset(reset), .EnM(EnM), .FlushE(FlushE),
    .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .FlagWriteE(FlagWriteE), .CondE(CondE), .RdE(RdE), .ALUFlags(ALUFlags),
    .ALUResultE(ALUResultE), .WriteDataE(WriteDataE),
    .Flags(Flags), .CondExE(CondExE), .BranchTakenE(BranchTakenE),
    .PCSrcM(PCSrcM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .RdM(RdM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM)
`ifdef COND_EXEC_SQUASH_CNT_EN
    , .SquashCount(SquashCount)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en, flush, pcsrc, regw, mtr, memw;
    logic [1:0]  fw;
    logic [3:0]  cond, rd, aluf;
    logic [31:0] alu, wd;
  } stim_t;

  typedef struct {
    logic [3:0] flags;
    logic [3:0] cond;
    logic       pass;
  } cond_vec_t;

  int nvec = 0;
  int nerr = 0;

  // Reference model state
  logic [3:0]  m_flags;
  logic        m_pcsrc, m_regw, m_mtr, m_memw;
  logic [3:0]  m_rd;
  logic [31:0] m_alu, m_wd;
  logic [15:0] m_sq;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Condition truth computed from the mnemonic pairs: odd codes below 0xF negate the even one.
  function automatic logic ref_cond(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v, r;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cond >> 1)
      3'd0: r = z;
      3'd1: r = c;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = c && !z;
      3'd5: r = (n == v);
      3'd6: r = !z && (n == v);
      default: r = 1'b1;
    endcase
    if (cond != 4'hF && cond[0]) r = !r;
    return r;
  endfunction

  function automatic stim_t nop();
    stim_t s;
    s.en = 1'b1; s.flush = 1'b0; s.pcsrc = 1'b0; s.regw = 1'b0; s.mtr = 1'b0; s.memw = 1'b0;
    s.fw = 2'b00; s.cond = 4'hE; s.rd = 4'h0; s.aluf = 4'h0; s.alu = 32'h0; s.wd = 32'h0;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.en    = ($urandom_range(0, 3) != 0);
    s.flush = ($urandom_range(0, 4) == 0);
    s.pcsrc = 1'($urandom); s.regw = 1'($urandom); s.mtr = 1'($urandom); s.memw = 1'($urandom);
    s.fw    = 2'($urandom); s.cond = 4'($urandom); s.rd = 4'($urandom);
    s.aluf  = 4'($urandom); s.alu = $urandom; s.wd = $urandom;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    EnM = s.en; FlushE = s.flush; PCSrcE = s.pcsrc; RegWriteE = s.regw; MemtoRegE = s.mtr;
    MemWriteE = s.memw; FlagWriteE = s.fw; CondE = s.cond; RdE = s.rd; ALUFlags = s.aluf;
    ALUResultE = s.alu; WriteDataE = s.wd;
  endtask

  task automatic model_reset();
    m_flags = 4'h0; m_pcsrc = 0; m_regw = 0; m_mtr = 0; m_memw = 0;
    m_rd = 4'h0; m_alu = 32'h0; m_wd = 32'h0; m_sq = 16'h0;
  endtask

  task automatic model_edge(input stim_t s);
    logic pass, ok;
    pass = ref_cond(s.cond, m_flags);
    ok   = pass && !s.flush;
    if (s.en) begin
      if (!s.flush && !pass && (s.pcsrc || s.regw || s.memw || s.fw != 2'b00)) m_sq = m_sq + 16'h1;
      m_pcsrc = s.pcsrc && ok;
      m_regw  = s.regw && ok;
      m_memw  = s.memw && ok;
      m_mtr   = s.mtr;
      m_rd    = s.rd;
      m_alu   = s.alu;
      m_wd    = s.wd;
      if (ok && s.fw[1]) m_flags[3:2] = s.aluf[3:2];
      if (ok && s.fw[0]) m_flags[1:0] = s.aluf[1:0];
    end
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".Flags"}, 32'(Flags), 32'(m_flags));
    check({tag, ".PCSrcM"}, 32'(PCSrcM), 32'(m_pcsrc));
    check({tag, ".RegWriteM"}, 32'(RegWriteM), 32'(m_regw));
    check({tag, ".MemtoRegM"}, 32'(MemtoRegM), 32'(m_mtr));
    check({tag, ".MemWriteM"}, 32'(MemWriteM), 32'(m_memw));
    check({tag, ".RdM"}, 32'(RdM), 32'(m_rd));
    check({tag, ".ALUResultM"}, ALUResultM, m_alu);
    check({tag, ".WriteDataM"}, WriteDataM, m_wd);
`ifdef COND_EXEC_SQUASH_CNT_EN
    check({tag, ".SquashCount"}, 32'(SquashCount), 32'(m_sq));
`endif
  endtask

  // Drive one instruction, check combinational outputs, clock it, check registers.
  task automatic apply(input string tag, input stim_t s);
    logic pass;
    drive(s);
    #1;
    pass = ref_cond(s.cond, m_flags);
    check({tag, ".CondExE"}, 32'(CondExE), 32'(pass));
    check({tag, ".BranchTakenE"}, 32'(BranchTakenE), 32'(s.pcsrc && pass && !s.flush));
    @(posedge clk);
    model_edge(s);
    #1;
    check_regs(tag);
  endtask

  // Reset held across a clock edge with a live instruction on the inputs.
  task automatic pulse_reset(input string tag);
    stim_t s;
    s = nop(); s.pcsrc = 1; s.regw = 1; s.memw = 1; s.mtr = 1; s.fw = 2'b11;
    s.aluf = 4'hF; s.rd = 4'h9; s.alu = 32'hDEAD_BEEF; s.wd = 32'h1234_5678;
    reset = 1'b1;
    drive(s);
    #1;
    model_reset();
    check_regs({tag, ".async"});
    @(posedge clk);
    #1;
    check_regs({tag, ".held"});
    reset = 1'b0;
  endtask

  cond_vec_t tbl[20];
  stim_t s;
  logic [3:0]  held_flags;
  logic [31:0] held_alu;

  initial begin
    tbl[0]  = '{4'b0100, 4'h0, 1'b1};
    tbl[1]  = '{4'b0000, 4'h0, 1'b0};
    tbl[2]  = '{4'b0000, 4'h1, 1'b1};
    tbl[3]  = '{4'b0010, 4'h2, 1'b1};
    tbl[4]  = '{4'b0010, 4'h3, 1'b0};
    tbl[5]  = '{4'b1000, 4'h4, 1'b1};
    tbl[6]  = '{4'b1000, 4'h5, 1'b0};
    tbl[7]  = '{4'b0001, 4'h6, 1'b1};
    tbl[8]  = '{4'b0000, 4'h7, 1'b1};
    tbl[9]  = '{4'b0010, 4'h8, 1'b1};
    tbl[10] = '{4'b0110, 4'h8, 1'b0};
    tbl[11] = '{4'b0110, 4'h9, 1'b1};
    tbl[12] = '{4'b1001, 4'hA, 1'b1};
    tbl[13] = '{4'b1000, 4'hB, 1'b1};
    tbl[14] = '{4'b0000, 4'hC, 1'b1};
    tbl[15] = '{4'b0100, 4'hC, 1'b0};
    tbl[16] = '{4'b0001, 4'hD, 1'b1};
    tbl[17] = '{4'b0000, 4'hD, 1'b0};
    tbl[18] = '{4'b0000, 4'hE, 1'b1};
    tbl[19] = '{4'b1111, 4'hF, 1'b1};

    reset = 1'b0;
    drive(nop());
    model_reset();
    #2;
    pulse_reset("rst0");

    // Set Z via a full flag write, then an EQ register write.
    s = nop(); s.fw = 2'b11; s.aluf = 4'b0100;
    apply("flagset", s);
    check("flagset.const", 32'(Flags), 32'h4);
    s = nop(); s.cond = 4'h0; s.regw = 1; s.rd = 4'h3;
    apply("eq_regw", s);
    check("eq_regw.const", 32'(RegWriteM), 32'h1);

    // Flags=0000: NE writes memory, EQ does not and leaves Flags alone.
    pulse_reset("rst1");
    s = nop(); s.cond = 4'h1; s.memw = 1;
    apply("ne_memw", s);
    check("ne_memw.const", 32'(MemWriteM), 32'h1);
    s = nop(); s.cond = 4'h0; s.memw = 1; s.fw = 2'b11; s.aluf = 4'hF;
    apply("eq_memw", s);
    check("eq_memw.const", 32'(MemWriteM), 32'h0);
    check("eq_memw.flags", 32'(Flags), 32'h0);

    // Half write: N,Z updated, C,V held.
    s = nop(); s.fw = 2'b10; s.aluf = 4'b1011;
    apply("half_nz", s);
    check("half_nz.const", 32'(Flags), 32'h8);

    // Three stalled cycles with changing inputs, then resume.
    held_flags = Flags;
    held_alu = ALUResultM;
    for (int i = 0; i < 3; i++) begin
      s = rand_stim(); s.en = 1'b0;
      apply("stall", s);
      check("stall.flags_const", 32'(Flags), 32'(held_flags));
      check("stall.alu_const", ALUResultM, held_alu);
    end
    s = nop(); s.alu = 32'hCAFE_0001; s.rd = 4'hA; s.regw = 1;
    apply("resume", s);
    check("resume.alu", ALUResultM, 32'hCAFE_0001);

    // Flushed vs unflushed always-branch.
    s = nop(); s.pcsrc = 1; s.flush = 1;
    apply("br_flush", s);
    check("br_flush.pcsrcm", 32'(PCSrcM), 32'h0);
    s.flush = 0;
    drive(s);
    #1;
    check("br_live.taken", 32'(BranchTakenE), 32'h1);
    apply("br_live", s);
    check("br_live.pcsrcm", 32'(PCSrcM), 32'h1);

    // Reset arriving in the middle of a stall drops the held instruction.
    s = nop(); s.regw = 1; s.memw = 1; s.rd = 4'h7; s.alu = 32'h55;
    apply("pre_stall", s);
    s.en = 0;
    apply("mid_stall", s);
    pulse_reset("rst_stall");

    // Condition-decode table.
    for (int i = 0; i < 20; i++) begin
      s = nop(); s.fw = 2'b11; s.aluf = tbl[i].flags;
      apply("tbl_setup", s);
      s = nop(); s.cond = tbl[i].cond; s.pcsrc = 1; s.regw = 1;
      drive(s);
      #1;
      check($sformatf("tbl%0d.cond", i), 32'(CondExE), 32'(tbl[i].pass));
      apply("tbl_run", s);
    end

    // Random traffic against the model, with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) pulse_reset("rnd_rst");
      else apply("rnd", rand_stim());
    end

`ifdef COND_EXEC_SQUASH_CNT_EN
    // Walk the counter to 0xFFFE with failing EQ writes, then wrap it.
    pulse_reset("sq_rst");
    s = nop(); s.cond = 4'h0; s.regw = 1;
    drive(s);
    for (int i = 0; i < 65534; i++) begin
      @(posedge clk);
      model_edge(s);
    end
    #1;
    check("sq.fffe", 32'(SquashCount), 32'hFFFE);
    apply("sq_fail1", s);
    apply("sq_fail2", s);
    check("sq.wrap", 32'(SquashCount), 32'h0);
    apply("sq_fail3", s);
    pulse_reset("sq_midrst");
    check("sq.rst", 32'(SquashCount), 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
